// File: rtl/apb_slave_mem_if.sv
// APB bus signal bundle between one requester and its completers.
// The master modport drives the request side; the slave modport answers with PREADY/PRDATA.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SLV_COUNT  = 4
) ();
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [SLV_COUNT-1:0]  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PREADY, PRDATA
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PREADY, PRDATA
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed memory, answering after a fixed number of
// wait states. PREADY and PRDATA come straight from flops.
module apb_slave_mem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SLV_COUNT   = 4,
    parameter int                    SLV_IDX     = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_slave_mem_if.slave  bus
);
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BPW);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * BPW);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic                  rng_q, rng_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr_cur;
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range_now;
    logic                  rng_cur;
    logic                  write_cur;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  mem_we;

    assign sel = bus.PSEL[SLV_IDX];

    // In IDLE the live bus address is decoded (SETUP); afterwards the latched one,
    // so address changes during ACCESS have no effect.
    assign addr_cur     = (state_q == ST_IDLE) ? bus.PADDR : addr_q;
    assign off          = addr_cur - BASE_ADDR;
    assign in_range_now = (off < SPAN);
    assign rng_cur      = (state_q == ST_IDLE) ? in_range_now : rng_q;
    assign write_cur    = (state_q == ST_IDLE) ? bus.PWRITE : write_q;
    assign idx          = off[BSH +: IDX_W];
    assign rd_word      = rng_cur ? mem[idx] : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        rng_d    = rng_q;
        pready_d = 1'b0;
        prdata_d = prdata_q;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel && !bus.PENABLE) begin
                    addr_d  = bus.PADDR;
                    write_d = bus.PWRITE;
                    rng_d   = in_range_now;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ST_READY;
                        pready_d = 1'b1;
                        if (!write_cur) prdata_d = rd_word;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (bus.PENABLE) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d  = ST_READY;
                        pready_d = 1'b1;
                        if (!write_cur) prdata_d = rd_word;
                    end
                end
            end
            ST_READY: begin
                // PREADY is high here, so sel&&PENABLE marks the completing edge.
                state_d = ST_IDLE;
                if (sel && bus.PENABLE && write_q && rng_q) mem_we = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            rng_q    <= 1'b0;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            rng_q    <= rng_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    // Storage is deliberately not reset; reset forces IDLE, which blocks any write.
    always_ff @(posedge PCLK) begin
        if (mem_we) mem[idx] <= bus.PWDATA;
    end

    assign bus.PREADY = pready_q;
    assign bus.PRDATA = prdata_q;

    logic unused_sig;
    assign unused_sig = ^{bus.PSEL, off};
endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one zero-wait instance on PSEL[0] and one
// three-wait instance on PSEL[1] share a single APB request bus.
module tb_apb_slave_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [3:0]  psel = '0;
    logic        penable = 1'b0;
    logic [31:0] pwdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4)) bus0 ();
    apb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_COUNT(4)) bus1 ();

    assign bus0.PADDR = paddr;   assign bus1.PADDR = paddr;
    assign bus0.PWRITE = pwrite; assign bus1.PWRITE = pwrite;
    assign bus0.PSEL = psel;     assign bus1.PSEL = psel;
    assign bus0.PENABLE = penable; assign bus1.PENABLE = penable;
    assign bus0.PWDATA = pwdata; assign bus1.PWDATA = pwdata;

    apb_slave_mem #(.SLV_IDX(0), .WAIT_CYCLES(0)) dut0 (.PCLK(clk), .PRESET(rst), .bus(bus0));
    apb_slave_mem #(.SLV_IDX(1), .WAIT_CYCLES(3)) dut1 (.PCLK(clk), .PRESET(rst), .bus(bus1));

    function automatic logic rdy(input int s);
        return (s == 1) ? bus1.PREADY : bus0.PREADY;
    endfunction

    function automatic logic [31:0] rd(input int s);
        return (s == 1) ? bus1.PRDATA : bus0.PRDATA;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer; PADDR is scrambled during ACCESS to prove it is latched.
    task automatic apb_xfer(input int s, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int waits);
        int cyc;
        @(negedge clk);
        psel = 4'(1 << s); paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        paddr   = addr ^ 32'h0000_00FC;
        cyc = 0;
        while (!rdy(s) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("pready_seen", {31'b0, rdy(s)}, 32'd1);
        rdata = rd(s);
        waits = cyc;
        $display("xfer dut%0d %s addr=%h wdata=%h prdata=%h waits=%0d",
                 s, wr ? "WR" : "RD", addr, wdata, rdata, waits);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel = '0; penable = 1'b0;
    endtask

    logic [31:0] rdata;
    int          waits;
    logic        seen;

    initial begin
        // Reset state
        #2;
        check_eq("rst_pready0", {31'b0, bus0.PREADY}, 32'd0);
        check_eq("rst_prdata0", bus0.PRDATA, 32'd0);
        check_eq("rst_pready1", {31'b0, bus1.PREADY}, 32'd0);
        check_eq("rst_prdata1", bus1.PRDATA, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        bus_idle();

        // Zero wait states: write then read at 0x10
        apb_xfer(0, 1'b1, 32'h10, 32'hA5A5_0001, rdata, waits);
        check_eq("w0_waits", 32'(waits), 32'd0);
        apb_xfer(0, 1'b0, 32'h10, 32'h0, rdata, waits);
        check_eq("r0_waits", 32'(waits), 32'd0);
        check_eq("r0_data", rdata, 32'hA5A5_0001);
        @(negedge clk);
        check_eq("r0_pready_drop", {31'b0, bus0.PREADY}, 32'd0);
        psel = '0; penable = 1'b0;

        // Three wait states: read at 0x04, PREADY exactly one cycle
        apb_xfer(1, 1'b1, 32'h04, 32'hCAFE_0004, rdata, waits);
        check_eq("w3_waits", 32'(waits), 32'd3);
        apb_xfer(1, 1'b0, 32'h04, 32'h0, rdata, waits);
        check_eq("r3_waits", 32'(waits), 32'd3);
        check_eq("r3_data", rdata, 32'hCAFE_0004);
        @(negedge clk);
        check_eq("r3_pready_one_cycle", {31'b0, bus1.PREADY}, 32'd0);
        psel = '0; penable = 1'b0;

        // Out of range: read gives 0, write does not alias onto word 0
        apb_xfer(0, 1'b1, 32'h0, 32'h1111_0000, rdata, waits);
        apb_xfer(0, 1'b0, 32'h400, 32'h0, rdata, waits);
        check_eq("oor_rd_data", rdata, 32'd0);
        check_eq("oor_rd_waits", 32'(waits), 32'd0);
        apb_xfer(0, 1'b1, 32'h400, 32'hDEAD_BEEF, rdata, waits);
        apb_xfer(0, 1'b0, 32'h0, 32'h0, rdata, waits);
        check_eq("word0_kept", rdata, 32'h1111_0000);
        apb_xfer(0, 1'b1, 32'h8, 32'h7777_7777, rdata, waits);
        check_eq("wr_keeps_prdata", rdata, 32'h1111_0000);

        // Back-to-back write then read, no idle cycle between
        apb_xfer(0, 1'b1, 32'h20, 32'h0000_1234, rdata, waits);
        apb_xfer(0, 1'b0, 32'h20, 32'h0, rdata, waits);
        check_eq("b2b_data0", rdata, 32'h0000_1234);
        apb_xfer(1, 1'b1, 32'h20, 32'h0000_5678, rdata, waits);
        apb_xfer(1, 1'b0, 32'h20, 32'h0, rdata, waits);
        check_eq("b2b_data1", rdata, 32'h0000_5678);
        bus_idle();

        // Abort during WAIT: select dropped, write must not land
        apb_xfer(1, 1'b1, 32'h30, 32'h0000_5555, rdata, waits);
        bus_idle();
        @(negedge clk);
        psel = 4'b0010; paddr = 32'h30; pwrite = 1'b1; pwdata = 32'h0000_9999; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        seen = bus1.PREADY;
        @(negedge clk);
        seen = seen | bus1.PREADY;
        psel = '0; penable = 1'b0;
        @(negedge clk);
        seen = seen | bus1.PREADY;
        @(negedge clk);
        seen = seen | bus1.PREADY;
        check_eq("abort_no_pready", {31'b0, seen}, 32'd0);
        apb_xfer(1, 1'b0, 32'h30, 32'h0, rdata, waits);
        check_eq("abort_mem_kept", rdata, 32'h0000_5555);
        check_eq("after_abort_waits", 32'(waits), 32'd3);
        bus_idle();

        // Select line of a third slave only: neither instance answers
        @(negedge clk);
        psel = 4'b0100; paddr = 32'h10; pwrite = 1'b0; penable = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            seen = seen | bus0.PREADY | bus1.PREADY;
            @(negedge clk);
        end
        check_eq("other_sel_silent", {31'b0, seen}, 32'd0);
        psel = '0; penable = 1'b0;

        // Reset pulse in the middle of WAIT
        @(negedge clk);
        psel = 4'b0010; paddr = 32'h04; pwrite = 1'b0; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_pready", {31'b0, bus1.PREADY}, 32'd0);
        check_eq("midrst_prdata", bus1.PRDATA, 32'd0);
        check_eq("midrst_prdata0", bus0.PRDATA, 32'd0);
        @(negedge clk);
        rst = 1'b0; psel = '0; penable = 1'b0;
        apb_xfer(1, 1'b0, 32'h04, 32'h0, rdata, waits);
        check_eq("post_rst_data", rdata, 32'hCAFE_0004);
        check_eq("post_rst_waits", 32'(waits), 32'd3);
        bus_idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
